// File: rtl/addsub16_nibble_seq.sv
// Sequential 16-bit add/subtract unit. One nibble is processed per clock through a
// single 4-bit carry look-ahead slice. The slice's group P/G forms the carry into the
// next nibble. The unit reports signed overflow, can optionally saturate, and returns
// Z/N flags taken from the final result.

// 4-bit carry look-ahead adder slice with group propagate/generate outputs.
module cla_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       p_o,
  output logic       g_o
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  // Bit propagate/generate, look-ahead carries, sum and group terms.
  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
    s_o  = p ^ c;
    p_o  = &p;
    g_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end
endmodule

module addsub16_nibble_seq #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Sum,
  output logic        Ovfl,
  output logic        Z,
  output logic        N
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        carry_q, carry_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;        // B already inverted for subtract
  logic [15:0] part_q, part_d;
  logic [15:0] sum_q, sum_d;
  logic        ovfl_q, ovfl_d;
  logic        z_q, z_d;
  logic        n_q, n_d;

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [3:0]  cla_s;
  logic        cla_p;
  logic        cla_g;
  logic [15:0] res_full;
  logic [15:0] res_final;
  logic        ovf;

  cla_4bit u_cla (
    .a_i (a_nib),
    .b_i (b_nib),
    .c_i (carry_q),
    .s_o (cla_s),
    .p_o (cla_p),
    .g_o (cla_g)
  );

  // Nibble select and final-step result/overflow formation.
  always_comb begin
    a_nib     = a_q[{idx_q, 2'b00} +: 4];
    b_nib     = b_q[{idx_q, 2'b00} +: 4];
    // Only meaningful on the last step, where cla_s is the top nibble.
    res_full  = {cla_s, part_q[11:0]};
    ovf       = (a_q[15] == b_q[15]) && (res_full[15] != a_q[15]);
    res_final = res_full;
    if (ovf && SATURATE) begin
      res_final = a_q[15] ? 16'h8000 : 16'h7FFF;
    end
  end

  // Next-state logic: accept in IDLE/DONE, ripple one nibble per BUSY cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    ovfl_d  = ovfl_q;
    z_d     = z_q;
    n_d     = n_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub;
          idx_d   = 2'd0;
          state_d = StBusy;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        part_d[{idx_q, 2'b00} +: 4] = cla_s;
        carry_d = cla_g | (cla_p & carry_q);
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          // Final carry-out is dropped; there is no unsigned carry flag.
          sum_d   = res_final;
          ovfl_d  = ovf;
          z_d     = (res_final == 16'h0000);
          n_d     = res_final[15];
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      carry_q <= 1'b0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      part_q  <= 16'h0000;
      sum_q   <= 16'h0000;
      ovfl_q  <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      ovfl_q  <= ovfl_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  // Status and result outputs.
  always_comb begin
    busy = (state_q == StBusy);
    done = (state_q == StDone);
    Sum  = sum_q;
    Ovfl = ovfl_q;
    Z    = z_q;
    N    = n_q;
  end

endmodule

// File: tb/tb_addsub16_nibble_seq.sv
// Testbench for addsub16_nibble_seq: a saturating and a wrapping instance share inputs.
// A scoreboard queue is filled at each accept and drained whenever done pulses.
module tb_addsub16_nibble_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;

  logic        busy_s, done_s, ovfl_s, z_s, n_s;
  logic [15:0] sum_s;
  logic        busy_w, done_w, ovfl_w, z_w, n_w;
  logic [15:0] sum_w;

  typedef struct {
    logic [15:0] sum_s;
    logic        ovf;
    logic        z_s;
    logic        n_s;
    logic [15:0] sum_w;
    logic        z_w;
    logic        n_w;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  addsub16_nibble_seq #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(a), .B(b),
    .busy(busy_s), .done(done_s), .Sum(sum_s), .Ovfl(ovfl_s), .Z(z_s), .N(n_s)
  );

  addsub16_nibble_seq #(.SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(a), .B(b),
    .busy(busy_w), .done(done_w), .Sum(sum_w), .Ovfl(ovfl_w), .Z(z_w), .N(n_w)
  );

  // Reference model straight from the arithmetic definition.
  function automatic exp_t model(input logic [15:0] op_a, input logic [15:0] op_b,
                                 input logic op_sub);
    exp_t        e;
    logic [15:0] beff;
    logic [15:0] full;
    beff    = op_sub ? ~op_b : op_b;
    full    = op_a + beff + {15'd0, op_sub};
    e.ovf   = (op_a[15] == beff[15]) && (full[15] != op_a[15]);
    e.sum_w = full;
    e.sum_s = e.ovf ? (op_a[15] ? 16'h8000 : 16'h7FFF) : full;
    e.z_s   = (e.sum_s == 16'h0000);
    e.n_s   = e.sum_s[15];
    e.z_w   = (e.sum_w == 16'h0000);
    e.n_w   = e.sum_w[15];
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest accepted op.
  always @(negedge clk) begin
    if (done_s || done_w) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got done_s=%b done_w=%b want no done", done_s, done_w);
      end else begin
        mon_e = sb_q.pop_front();
        if ({done_s, sum_s, ovfl_s, z_s, n_s} !== {1'b1, mon_e.sum_s, mon_e.ovf, mon_e.z_s,
                                                   mon_e.n_s}) begin
          errors++;
          $display("FAIL result_sat got done=%b Sum=%h Ovfl=%b Z=%b N=%b want 1 %h %b %b %b",
                   done_s, sum_s, ovfl_s, z_s, n_s, mon_e.sum_s, mon_e.ovf, mon_e.z_s, mon_e.n_s);
        end
        checks++;
        if ({done_w, sum_w, ovfl_w, z_w, n_w} !== {1'b1, mon_e.sum_w, mon_e.ovf, mon_e.z_w,
                                                   mon_e.n_w}) begin
          errors++;
          $display("FAIL result_wrap got done=%b Sum=%h Ovfl=%b Z=%b N=%b want 1 %h %b %b %b",
                   done_w, sum_w, ovfl_w, z_w, n_w, mon_e.sum_w, mon_e.ovf, mon_e.z_w, mon_e.n_w);
        end
      end
    end
  end

  // Drive one request in a cycle where the DUT accepts; returns just after the accept edge.
  task automatic issue(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_sub);
    a     = op_a;
    b     = op_b;
    sub   = op_sub;
    start = 1'b1;
    sb_q.push_back(model(op_a, op_b, op_sub));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; reports cycles waited and busy cycles seen.
  task automatic wait_done(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (!done_s && lat < 12) begin
      if (busy_s) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat, bcyc;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_s, done_s, sum_s, ovfl_s, z_s, n_s, busy_w, done_w, sum_w, ovfl_w, z_w, n_w} !== '0)
    begin
      errors++;
      $display("FAIL reset_init got busy=%b done=%b Sum=%h Ovfl=%b Z=%b N=%b want all zero",
               busy_s, done_s, sum_s, ovfl_s, z_s, n_s);
    end
    rst = 1'b0;
    // Leave a nonzero result behind, then reset in the middle of a random op.
    issue(16'h0F0F, 16'h1010, 1'b0);
    wait_done(lat, bcyc);
    issue(16'($urandom()), 16'($urandom()), 1'($urandom()));
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; a = 16'($urandom()); b = 16'($urandom());
    @(posedge clk); #1;
    sb_q.delete();
    @(posedge clk); #1;
    checks++;
    if ({busy_s, done_s, sum_s, ovfl_s, z_s, n_s} !== '0) begin
      errors++;
      $display("FAIL reset_mid_random got busy=%b done=%b Sum=%h Ovfl=%b Z=%b N=%b want all zero",
               busy_s, done_s, sum_s, ovfl_s, z_s, n_s);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy_s !== 1'b0) begin
      errors++;
      $display("FAIL start_during_rst got busy=%b want 0", busy_s);
    end
  endtask

  task automatic test_basic_add();
    int lat, bcyc;
    issue(16'h1234, 16'h0F0F, 1'b0);
    wait_done(lat, bcyc);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL basic_latency got %0d want 4", lat);
    end
    checks++;
    if (bcyc != 4) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d want 4", bcyc);
    end
    checks++;
    if ({sum_s, ovfl_s, z_s, n_s} !== {16'h2143, 3'b000}) begin
      errors++;
      $display("FAIL basic_value got Sum=%h OZN=%b%b%b want 2143 000", sum_s, ovfl_s, z_s, n_s);
    end
    @(posedge clk); #1;
    checks++;
    if ({done_s, busy_s} !== 2'b00) begin
      errors++;
      $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", done_s, busy_s);
    end
  endtask

  task automatic test_carry_sub();
    logic [15:0] va[3] = '{16'hFFFF, 16'h0005, 16'h0003};
    logic [15:0] vb[3] = '{16'h0001, 16'h0005, 16'h0007};
    logic        vs[3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] vr[3] = '{16'h0000, 16'h0000, 16'hFFFC};
    logic [1:0]  vzn[3] = '{2'b10, 2'b10, 2'b01};
    int lat, bcyc;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], vs[i]);
      wait_done(lat, bcyc);
      checks++;
      if ({sum_s, ovfl_s, z_s, n_s} !== {vr[i], 1'b0, vzn[i]}) begin
        errors++;
        $display("FAIL carry_sub_%0d got Sum=%h O=%b ZN=%b%b want %h 0 %b", i, sum_s, ovfl_s,
                 z_s, n_s, vr[i], vzn[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] va[2] = '{16'h7FFF, 16'h8000};
    logic [15:0] vs_sat[2] = '{16'h7FFF, 16'h8000};
    logic [15:0] vs_wrp[2] = '{16'h8000, 16'h7FFF};
    logic        vsub[2] = '{1'b0, 1'b1};
    int lat, bcyc;
    for (int i = 0; i < 2; i++) begin
      issue(va[i], 16'h0001, vsub[i]);
      wait_done(lat, bcyc);
      checks++;
      if ({sum_s, ovfl_s, n_s, sum_w, ovfl_w} !==
          {vs_sat[i], 1'b1, vs_sat[i][15], vs_wrp[i], 1'b1}) begin
        errors++;
        $display("FAIL overflow_%0d got sat=%h/%b N=%b wrap=%h/%b want %h/1 %b %h/1", i, sum_s,
                 ovfl_s, n_s, sum_w, ovfl_w, vs_sat[i], vs_sat[i][15], vs_wrp[i]);
      end
    end
  endtask

  task automatic test_start_in_busy();
    int lat, bcyc;
    issue(16'h4000, 16'h0123, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcyc);
    checks++;
    if (lat != 2 || sum_s !== 16'h4123) begin
      errors++;
      $display("FAIL start_in_busy got lat=%0d Sum=%h want 2 4123", lat, sum_s);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_s !== 1'b0) begin
      errors++;
      $display("FAIL start_in_busy_idle got busy=%b want 0", busy_s);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcyc;
    issue(16'h1234, 16'h1111, 1'b0);
    wait_done(lat, bcyc);
    // Held start in the DONE cycle launches the next op.
    a = 16'h0F00; b = 16'h0100; sub = 1'b1; start = 1'b1;
    sb_q.push_back(model(16'h0F00, 16'h0100, 1'b1));
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy_s, done_s, sum_s} !== {2'b10, 16'h2345}) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b done=%b Sum=%h want 1 0 2345", busy_s, done_s, sum_s);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sum_s !== 16'h2345) begin
      errors++;
      $display("FAIL b2b_sum_hold got Sum=%h want 2345", sum_s);
    end
    wait_done(lat, bcyc);
    checks++;
    if (lat != 2 || sum_s !== 16'h0E00) begin
      errors++;
      $display("FAIL b2b_second got lat_rem=%0d Sum=%h want 2 0e00", lat, sum_s);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bcyc;
    int dones;
    issue(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    checks++;
    if ({busy_s, done_s, sum_s, ovfl_s, z_s, n_s} !== '0) begin
      errors++;
      $display("FAIL rst_mid_op got busy=%b done=%b Sum=%h OZN=%b%b%b want all zero",
               busy_s, done_s, sum_s, ovfl_s, z_s, n_s);
    end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_s) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL rst_no_done got %0d done pulses want 0", dones);
    end
    issue(16'h1111, 16'h2222, 1'b0);
    wait_done(lat, bcyc);
    checks++;
    if (lat != 4 || sum_s !== 16'h3333) begin
      errors++;
      $display("FAIL rst_recover got lat=%0d Sum=%h want 4 3333", lat, sum_s);
    end
  endtask

  task automatic test_random();
    int lat, bcyc;
    for (int i = 0; i < 10; i++) begin
      issue(16'($urandom()), 16'($urandom()), 1'($urandom()));
      wait_done(lat, bcyc);
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL random_latency_%0d got %0d want 4", i, lat);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_add();
    test_carry_sub();
    test_overflow();
    test_start_in_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub16_nibble_seq.md
# addsub16_nibble_seq

Sequential 16-bit add/subtract unit built on the 4-bit carry look-ahead adder. It processes one nibble per clock through a single internal `cla_4bit` instance and uses that slice's group `P`/`G` to form the carry into the next nibble. It sits in the execute stage as the multi-cycle arithmetic path for ADD/SUB. It reports 2's-complement overflow and optionally saturates, and returns Z/N flags for the flag register.

## Interface
- `SATURATE`, default 1: 1 = clamp signed overflow to 0x7FFF/0x8000; 0 = wrap.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `sub`  in  1  0 = A+B, 1 = A−B; sampled with `start`.
- `A`  in  16  operand A; sampled with `start`.
- `B`  in  16  operand B; sampled with `start`.
- `busy`  out  1  operation in progress (BUSY state).
- `done`  out  1  one-cycle pulse: result valid.
- `Sum`  out  16  result register; holds until the next completion.
- `Ovfl`  out  1  signed overflow of last op; held with `Sum`.
- `Z`  out  1  `Sum == 0`, from the final, post-saturation value.
- `N`  out  1  `Sum[15]`, from the final, post-saturation value.

## Operation
- States: IDLE, BUSY, DONE. Reset enters IDLE.
- Reset values: all outputs 0. Internal nibble index, carry register, operand latches and partial accumulator are also 0.
- IDLE, `start`=1:
  - Latch `A` and `Beff` = `sub ? ~B : B`.
  - Carry register = `sub`.
  - Index = 0. Go to BUSY.
- BUSY, each cycle:
  - Feed nibble[index] of `A` and `Beff`, plus the carry register, to `cla_4bit`.
  - Write its `Sum` into partial[index].
  - Carry register ← `G | (P & carry)`. Index += 1.
- Index 3 is the final step:
  - Compute `ovf` = (`A[15]` == `Beff[15]`) && (result bit 15 != `A[15]`).
  - Load `Sum` from the full partial result, or with `{0x7FFF if A[15]=0, 0x8000 if A[15]=1}` when `ovf && SATURATE`.
  - Load `Ovfl` = `ovf`, `Z`, `N`. Go to DONE.
- DONE: `done`=1 for exactly one cycle.
  - If `start`=1, accept a new op exactly as from IDLE and go to BUSY (back-to-back). Otherwise go to IDLE.
- `start` in BUSY is ignored; latched operands are unaffected.
- Final carry-out is discarded (no unsigned carry flag).
- `A`/`B`/`sub` may change freely after the accepting edge.

## Timing
- Accept edge E0: `start` sampled high in IDLE or DONE. `busy`=1 after E0.
- Nibbles 0..3 are computed on edges E1..E4. Outputs update at E4.
- After E4: `busy`=0 and `done`=1 for one cycle. Latency is 4 cycles from the accepting edge to `done`.
- Throughput: with back-to-back start, a new op every 5 cycles.
- `Sum`/`Ovfl`/`Z`/`N` change only at the E4 edge (or reset). They are stable throughout BUSY, showing the previous result.
- `rst` in any state:
  - Next edge forces IDLE and zeroes all outputs.
  - No `done` for an aborted op. `start` in the same cycle as `rst` is ignored.

## Test plan
- Reset: assert `rst` 2 cycles mid-random activity -> all outputs 0, `busy`=0; `start` with `rst`=1 is not accepted.
- Basic add: `A`=0x1234, `B`=0x0F0F, `sub`=0 -> `done` exactly 4 cycles after accept, `Sum`=0x2143, `Ovfl`=0, `Z`=0, `N`=0; `busy` high for exactly 4 cycles.
- Full carry chain: 0xFFFF+0x0001 -> `Sum`=0x0000, `Z`=1, `Ovfl`=0. Subtract: 0x0005−0x0005 -> `Sum`=0x0000, `Z`=1. Negative result: 0x0003−0x0007 -> 0xFFFC, `N`=1.
- Overflow, `SATURATE`=1:
  - 0x7FFF+0x0001 -> `Sum`=0x7FFF, `Ovfl`=1, `N`=0.
  - 0x8000−0x0001 -> `Sum`=0x8000, `Ovfl`=1, `N`=1.
  - With `SATURATE`=0, the same ops give 0x8000 and 0x7FFF, `Ovfl`=1.
- Handshake:
  - `start` pulsed with new operands during BUSY -> ignored; result matches the first op.
  - `start` held high in the DONE cycle -> second op accepted, its `done` arrives 4 cycles later.
  - `Sum` holds the first result until then.
- Reset mid-op: accept 0x1111+0x2222, assert `rst` at the E2 edge -> IDLE next cycle, `done` never pulses, `Sum`=0. A subsequent op completes correctly.
